ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

- Drains the PS/2 receiver FIFO (`ready` / `nextdata_n` / `overflow` interface) with a strict one-pop-per-byte handshake.
- Assembles break (`F0`) and extended (`E0`) prefixes into complete key events and tracks modifier state (shift, ctrl, capslock).
- Emits one-cycle event strobes to the display and ASCII stages.
- Is the only block allowed to drive `nextdata_n`.

## Interface
Parameters:
- `EVT_MOD`, 100: event counter modulus; counter runs 0..EVT_MOD-1.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `clr`  in  1  reset; synchronous, active-high.
- `ready`  in  1  FIFO non-empty; `data` valid.
- `data`  in  8  FIFO head byte.
- `overflow`  in  1  FIFO overflow flag.
- `nextdata_n`  out  1  FIFO pop, active-low, registered.
- `key_valid`  out  1  one-cycle event strobe.
- `key_code`  out  8  scan code of the last event (prefixes stripped).
- `key_make`  out  1  1 = press, 0 = release.
- `key_ext`  out  1  event was `E0`-prefixed.
- `shift_flag`  out  1  left (`12`) or right (`59`) shift held.
- `ctrl_flag`  out  1  ctrl (`14`, plain or `E0`) held.
- `capslock_flag`  out  1  capslock toggle state.
- `ovf_err`  out  1  sticky overflow seen.
- `evt_count`  out  8  emitted-event count, modulo `EVT_MOD`.

## Operation
- FSM states: IDLE, POP, WAIT.
  - IDLE: if `ready`, capture `data` into `byte_r` and go to POP; otherwise stay.
  - POP: `nextdata_n` = 0 for exactly this cycle. The byte is decoded on the exit edge. Go to WAIT.
  - WAIT: `nextdata_n` = 1 and `ready` is ignored, so the FIFO pointer can settle. Return to IDLE.
- Decode of `byte_r`:
  - `F0`: set `brk_pend`. No event.
  - `E0`: set `ext_pend`. No event.
  - `E1`: discarded. Prefixes unchanged.
  - `00`/`FF` (keyboard error codes): discarded. Clear both prefixes.
  - Any other byte: event with `key_code`=byte, `key_make`=!`brk_pend`, `key_ext`=`ext_pend`. Clear both prefixes.
- Modifiers, applied on every event before filtering:
  - Shift: `shift_flag` = `lshift_held` | `rshift_held`.
  - Ctrl: `14` or `E0 14` sets/clears `lctrl_held` / `rctrl_held`; `ctrl_flag` is their OR.
  - Capslock (`58`): toggles `capslock_flag` only on a make when `caps_held`=0. The make sets `caps_held`; the break clears it. Auto-repeat makes never toggle.
- `evt_count`:
  - Increments on each asserted `key_valid`.
  - Wraps from EVT_MOD-1 to 0.
  - 8-bit; EVT_MOD must be ≤ 256.
- Overflow:
  - `overflow`=1 sampled on any edge sets `ovf_err` (sticky until `clr`).
  - The same edge clears `brk_pend`/`ext_pend` (stream resync).
  - The FSM keeps draining.
- Reset values:
  - `nextdata_n`=1.
  - All other outputs 0.
  - State IDLE; prefixes, held bits and `byte_r` 0.
- Reset mid-operation: `clr` in POP or WAIT forces IDLE and `nextdata_n`=1 on the next edge. A byte already popped is dropped and emits no event.

## Timing
- `ready` seen high in IDLE at edge T:
  - `nextdata_n` is low during T+1 only.
  - `key_valid` is high during T+2 only.
  - Modifier flags, `key_code`/`key_make`/`key_ext` and `evt_count` update at the same edge that raises `key_valid`.
- Maximum throughput: one byte per 3 cycles. A 3-byte `E0 F0 xx` sequence yields its event 8 cycles after the first `ready`, with back-to-back bytes.
- `key_code`/`key_make`/`key_ext` hold their value until the next event.
- `ready` dropping during POP/WAIT has no effect.
- Simultaneous `overflow` and event decode: the event is emitted with the pre-clear prefixes, then the prefixes are cleared.

## Configuration
- `PS2_REPEAT_FILTER_EN` defined:
  - Record `last_make` = {ext, code} on each emitted make.
  - A make equal to `last_make` is suppressed: no `key_valid`, no `evt_count` increment, modifiers unaffected.
  - A break matching `last_make` clears it (stored as 0, code 00 never matches).
  - A different make replaces it.
- Not defined: every make, including typematic repeats, emits `key_valid`. Capslock toggling is identical in both builds.

## Test plan
- Reset, then `ready`=1 with `data`=`1C` → `nextdata_n` low for exactly 1 cycle; `key_valid` one cycle later with `key_code`=`1C`, `key_make`=1, `key_ext`=0, `evt_count`=1.
- Bytes `E0`,`F0`,`75` → single event `key_code`=`75`, `key_make`=0, `key_ext`=1; exactly 3 `nextdata_n` pulses; no events for the prefixes.
- `12`,`1C`,`F0`,`12` → `shift_flag`=1 from the first event until the `F0 12` event, then 0.
- `58`,`58`,`58`,`F0`,`58`,`58` → `capslock_flag` goes 1, stays 1 through the repeats and the release, returns 0 on the final make.
- `1C` repeated ×3 → 1 event with `PS2_REPEAT_FILTER_EN`, 3 events without; 100 distinct events from reset → `evt_count` wraps to 0.
- Assert `overflow` between `F0` and `1C` → `ovf_err`=1 and stays 1; `1C` is reported as a make. Assert `clr` during POP → `nextdata_n`=1 next cycle, no `key_valid`, `ovf_err`=0.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: drains the receiver FIFO and builds key events and modifier state.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic repeat makes.
module ps2_key_sequencer #(
  parameter int EVT_MOD = 100
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_make,
  output logic       key_ext,
  output logic       shift_flag,
  output logic       ctrl_flag,
  output logic       capslock_flag,
  output logic       ovf_err,
  output logic [7:0] evt_count
);

  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_make_q, key_make_d;
  logic       key_ext_q, key_ext_d;
  logic       brk_pend_q, brk_pend_d;
  logic       ext_pend_q, ext_pend_d;
  logic       lshift_held_q, lshift_held_d;
  logic       rshift_held_q, rshift_held_d;
  logic       lctrl_held_q, lctrl_held_d;
  logic       rctrl_held_q, rctrl_held_d;
  logic       caps_held_q, caps_held_d;
  logic       shift_flag_q, shift_flag_d;
  logic       ctrl_flag_q, ctrl_flag_d;
  logic       capslock_q, capslock_d;
  logic       ovf_err_q, ovf_err_d;
  logic [7:0] evt_count_q, evt_count_d;
  logic       emit, is_make, is_ext;
`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] last_make_q, last_make_d;
  logic [8:0] key_full;
`endif

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    nextdata_n_d  = 1'b1;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_make_d    = key_make_q;
    key_ext_d     = key_ext_q;
    brk_pend_d    = brk_pend_q;
    ext_pend_d    = ext_pend_q;
    lshift_held_d = lshift_held_q;
    rshift_held_d = rshift_held_q;
    lctrl_held_d  = lctrl_held_q;
    rctrl_held_d  = rctrl_held_q;
    caps_held_d   = caps_held_q;
    capslock_d    = capslock_q;
    ovf_err_d     = ovf_err_q;
    evt_count_d   = evt_count_q;
    emit          = 1'b0;
    is_make       = !brk_pend_q;
    is_ext        = ext_pend_q;
`ifdef PS2_REPEAT_FILTER_EN
    last_make_d   = last_make_q;
    key_full      = {ext_pend_q, byte_q};
`endif
    case (state_q)
      IDLE: begin
        if (ready) begin
          byte_d       = data;
          state_d      = POP;
          nextdata_n_d = 1'b0;
        end
      end
      POP: begin
        state_d = WAIT;
        case (byte_q)
          8'hF0: brk_pend_d = 1'b1;
          8'hE0: ext_pend_d = 1'b1;
          8'hE1: ;
          8'h00, 8'hFF: begin
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
          end
          default: begin
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
            emit       = 1'b1;
            case (byte_q)
              8'h12: lshift_held_d = is_make;
              8'h59: rshift_held_d = is_make;
              8'h14: begin
                if (is_ext) rctrl_held_d = is_make;
                else        lctrl_held_d = is_make;
              end
              8'h58: begin
                // Only the first make of a press toggles; auto-repeat makes see caps_held set.
                if (is_make && !caps_held_q) capslock_d = !capslock_q;
                caps_held_d = is_make;
              end
              default: ;
            endcase
`ifdef PS2_REPEAT_FILTER_EN
            if (is_make && key_full == last_make_q) emit = 1'b0;
            else if (is_make)                       last_make_d = key_full;
            else if (key_full == last_make_q)       last_make_d = 9'h000;
`endif
            if (emit) begin
              key_valid_d = 1'b1;
              key_code_d  = byte_q;
              key_make_d  = is_make;
              key_ext_d   = is_ext;
              evt_count_d = (evt_count_q == 8'(EVT_MOD - 1)) ? 8'h00 : evt_count_q + 8'h01;
            end
          end
        endcase
      end
      WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Overflow resyncs the prefix tracker after any event has already used the old prefixes.
    if (overflow) begin
      ovf_err_d  = 1'b1;
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end
    shift_flag_d = lshift_held_d | rshift_held_d;
    ctrl_flag_d  = lctrl_held_d | rctrl_held_d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= IDLE;
      byte_q        <= 8'h00;
      nextdata_n_q  <= 1'b1;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_make_q    <= 1'b0;
      key_ext_q     <= 1'b0;
      brk_pend_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
      lshift_held_q <= 1'b0;
      rshift_held_q <= 1'b0;
      lctrl_held_q  <= 1'b0;
      rctrl_held_q  <= 1'b0;
      caps_held_q   <= 1'b0;
      shift_flag_q  <= 1'b0;
      ctrl_flag_q   <= 1'b0;
      capslock_q    <= 1'b0;
      ovf_err_q     <= 1'b0;
      evt_count_q   <= 8'h00;
`ifdef PS2_REPEAT_FILTER_EN
      last_make_q   <= 9'h000;
`endif
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_make_q    <= key_make_d;
      key_ext_q     <= key_ext_d;
      brk_pend_q    <= brk_pend_d;
      ext_pend_q    <= ext_pend_d;
      lshift_held_q <= lshift_held_d;
      rshift_held_q <= rshift_held_d;
      lctrl_held_q  <= lctrl_held_d;
      rctrl_held_q  <= rctrl_held_d;
      caps_held_q   <= caps_held_d;
      shift_flag_q  <= shift_flag_d;
      ctrl_flag_q   <= ctrl_flag_d;
      capslock_q    <= capslock_d;
      ovf_err_q     <= ovf_err_d;
      evt_count_q   <= evt_count_d;
`ifdef PS2_REPEAT_FILTER_EN
      last_make_q   <= last_make_d;
`endif
    end
  end

  assign nextdata_n    = nextdata_n_q;
  assign key_valid     = key_valid_q;
  assign key_code      = key_code_q;
  assign key_make      = key_make_q;
  assign key_ext       = key_ext_q;
  assign shift_flag    = shift_flag_q;
  assign ctrl_flag     = ctrl_flag_q;
  assign capslock_flag = capslock_q;
  assign ovf_err       = ovf_err_q;
  assign evt_count     = evt_count_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Scoreboard bench for ps2_key_sequencer: emulated FIFO, key-event reference model, decoupled monitor.
module tb_ps2_key_sequencer;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       overflow = 1'b0;
  logic       nextdata_n, key_valid, key_make, key_ext;
  logic       shift_flag, ctrl_flag, capslock_flag, ovf_err;
  logic [7:0] key_code, evt_count;

  ps2_key_sequencer #(.EVT_MOD(100)) dut (
    .clk(clk), .clr(clr), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_make(key_make), .key_ext(key_ext), .shift_flag(shift_flag),
    .ctrl_flag(ctrl_flag), .capslock_flag(capslock_flag), .ovf_err(ovf_err),
    .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       make, ext, shift, ctrl, caps;
    int         cnt;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, pop_cnt = 0;

  // Reference model state: a keyboard's view of prefixes and held keys.
  logic m_brk, m_ext, m_lsh, m_rsh, m_lc, m_rc, m_caps, m_caps_held;
  logic [8:0] m_last;
  int   m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_brk = 0; m_ext = 0; m_lsh = 0; m_rsh = 0; m_lc = 0; m_rc = 0;
    m_caps = 0; m_caps_held = 0; m_last = '0; m_cnt = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic mk, ex, emit;
    ev_t  e;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hE1) begin end
    else if (b == 8'h00 || b == 8'hFF) begin m_brk = 0; m_ext = 0; end
    else begin
      mk = !m_brk; ex = m_ext; m_brk = 0; m_ext = 0; emit = 1;
      if (b == 8'h12) m_lsh = mk;
      if (b == 8'h59) m_rsh = mk;
      if (b == 8'h14 && ex) m_rc = mk;
      if (b == 8'h14 && !ex) m_lc = mk;
      if (b == 8'h58) begin
        if (mk && !m_caps_held) m_caps = !m_caps;
        m_caps_held = mk;
      end
`ifdef PS2_REPEAT_FILTER_EN
      if (mk && {ex, b} == m_last) emit = 0;
      else if (mk) m_last = {ex, b};
      else if ({ex, b} == m_last) m_last = '0;
`endif
      if (emit) begin
        m_cnt = (m_cnt + 1) % 100;
        e.code = b; e.make = mk; e.ext = ex; e.shift = m_lsh | m_rsh;
        e.ctrl = m_lc | m_rc; e.caps = m_caps; e.cnt = m_cnt;
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic send(input logic [7:0] b);
    model_byte(b);
    fifo.push_back(b);
  endtask

  task automatic drain();
    int t = 0;
    while (fifo.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (fifo.size() != 0) chk("drain_timeout", fifo.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    fifo.delete();
    repeat (2) @(negedge clk);
    clr = 1'b0;
    model_reset();
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_flags", {key_make, key_ext, shift_flag, ctrl_flag, capslock_flag, ovf_err}, 0);
    chk("rst_evt_count", evt_count, 0);
  endtask

  // Emulated receiver FIFO: pops on a low nextdata_n at the clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!nextdata_n) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      ready = (fifo.size() != 0);
      data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end
  end

  // Monitor: pops the scoreboard on every event strobe.
  initial begin
    int   ndn_cyc = -10;
    logic prev_ndn = 1'b1, prev_kv = 1'b0;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (!nextdata_n && !prev_ndn) chk("nextdata_n_width", 2, 1);
      if (!nextdata_n) ndn_cyc = cyc;
      if (key_valid) begin
        if (prev_kv) chk("key_valid_width", 2, 1);
        chk("event_latency", cyc - ndn_cyc, 1);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_event: got code %0h expected none", key_code);
        end else begin
          e = exp_q.pop_front();
          chk("ev_code", key_code, e.code);
          chk("ev_make_ext", {key_make, key_ext}, {e.make, e.ext});
          chk("ev_mods", {shift_flag, ctrl_flag, capslock_flag}, {e.shift, e.ctrl, e.caps});
          chk("ev_count", evt_count, e.cnt);
        end
      end
      prev_ndn = nextdata_n;
      prev_kv  = key_valid;
    end
  end

  initial begin
    logic [7:0] pool [9] = '{8'h1C, 8'h12, 8'h59, 8'h14, 8'h58, 8'h1B, 8'h23, 8'h75, 8'h6B};
    int p0, t;
    do_reset();

    // Single make
    send(8'h1C); drain();
    chk("t1_code", key_code, 8'h1C);
    chk("t1_make_ext", {key_make, key_ext}, 2'b10);
    chk("t1_count", evt_count, 1);

    // Extended break: three pops, one event
    p0 = pop_cnt;
    send(8'hE0); send(8'hF0); send(8'h75); drain();
    chk("t2_pops", pop_cnt - p0, 3);
    chk("t2_code", key_code, 8'h75);
    chk("t2_make_ext", {key_make, key_ext}, 2'b01);

    // Shift tracking
    send(8'h12); drain();
    chk("shift_on", shift_flag, 1);
    send(8'h1C); send(8'hF0); drain();
    chk("shift_held", shift_flag, 1);
    send(8'h12); drain();
    chk("shift_off", shift_flag, 0);

    // Capslock toggling with repeats
    send(8'h58); drain();
    chk("caps_on", capslock_flag, 1);
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); drain();
    chk("caps_held", capslock_flag, 1);
    send(8'h58); drain();
    chk("caps_off", capslock_flag, 0);

    // Typematic repeat
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); drain();
`ifdef PS2_REPEAT_FILTER_EN
    chk("repeat_count", evt_count, 1);
`else
    chk("repeat_count", evt_count, 3);
`endif

    // Counter wrap after 100 distinct events
    do_reset();
    for (int i = 0; i < 100; i++) send((i % 2 == 0) ? 8'h1C : 8'h1B);
    drain();
    chk("wrap_count", evt_count, 0);

    // Overflow between a break prefix and the key
    do_reset();
    send(8'hF0); drain();
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    m_brk = 0; m_ext = 0;
    send(8'h1C); drain();
    chk("ovf_err_set", ovf_err, 1);
    chk("ovf_make", key_make, 1);

    // Randomized stream
    for (int i = 0; i < 240; i++) begin
      t = $urandom_range(0, 19);
      if (t < 2) send(8'hE0);
      else if (t < 5) send(8'hF0);
      else if (t == 5) send(8'hE1);
      else if (t == 6) send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
      else send(pool[$urandom_range(0, 8)]);
      if (i % 20 == 19) drain();
    end
    drain();
    chk("ovf_err_sticky", ovf_err, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    // Reset during POP drops the popped byte
    fifo.push_back(8'h1C);
    t = 0;
    while (nextdata_n && t < 100) begin @(negedge clk); t++; end
    chk("pop_seen", nextdata_n, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    chk("clr_nextdata_n", nextdata_n, 1);
    chk("clr_ovf_err", ovf_err, 0);
    repeat (6) @(negedge clk);
    chk("clr_no_event", evt_count, 0);
    chk("clr_fifo_popped", fifo.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
